note_sequencer: RTL and testbench

- Score-stepping controller that sits directly upstream of the music player's note mux.
- Walks an external score ROM of {note select, duration} entries.
- Drives the mux select so the chosen note generator (or the pause source) reaches the speaker for the scored number of tempo ticks.
- Inserts an articulation gap of silence between notes.
- Supports start, stop and looping playback.

---
 rtl/note_sequencer.sv | 153 +++++++++++++++
 tb/tb_note_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Score-stepping controller: walks a {select, duration} score ROM and steers the music
// player's note mux, silencing the output for an articulation gap after every note.
module note_sequencer #(
    parameter int CLK_HZ    = 25000000,
    parameter int TICK_HZ   = 64,
    parameter int SEL_W     = 2,
    parameter int REST_SEL  = 3,
    parameter int ADDR_W    = 4,
    parameter int DUR_W     = 6,
    parameter int GAP_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop,
    output logic [ADDR_W-1:0]       score_addr,
    input  logic [SEL_W+DUR_W-1:0]  score_data,
    output logic [SEL_W-1:0]        select,
    output logic                    playing,
    output logic                    done
);
    localparam int                DIV       = CLK_HZ / TICK_HZ;
    localparam int                CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0]  REST      = SEL_W'(REST_SEL);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DUR_W-1:0]  GAP_LEN   = DUR_W'(GAP_TICKS);
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t            r_state, w_state_nxt, w_adv_state;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_adv_addr;
    logic [SEL_W-1:0]  r_note, w_note_nxt;
    logic [SEL_W-1:0]  r_select, w_select_nxt;
    logic [DUR_W-1:0]  r_rem, w_rem_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_playing, r_done, w_done_nxt;
    logic              w_tick, w_timed;
    logic [SEL_W-1:0]  w_rom_sel;
    logic [DUR_W-1:0]  w_rom_dur;

    assign w_rom_sel   = score_data[SEL_W+DUR_W-1:DUR_W];
    assign w_rom_dur   = score_data[DUR_W-1:0];
    assign w_tick      = (r_cnt == CNT_LAST);
    assign w_timed     = (r_state == S_PLAY) || (r_state == S_GAP);
    // The last address never increments; it always routes through end-of-score handling.
    assign w_adv_state = (r_addr == ADDR_LAST) ? S_END : S_FETCH;
    assign w_adv_addr  = (r_addr == ADDR_LAST) ? r_addr : r_addr + ADDR_W'(1);

    // Next-state, datapath and output decode; stop overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_note_nxt  = r_note;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_addr_nxt  = {ADDR_W{1'b0}};
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_FETCH: w_state_nxt = S_LOAD;
                S_LOAD: begin
                    if (w_rom_dur == {DUR_W{1'b0}}) begin
                        w_state_nxt = S_END;
                    end else begin
                        w_note_nxt  = w_rom_sel;
                        w_rem_nxt   = w_rom_dur;
                        w_state_nxt = S_PLAY;
                    end
                end
                S_PLAY, S_GAP: begin
                    if (!w_tick) begin
                        w_rem_nxt = r_rem;
                    end else if (r_rem != DUR_ONE) begin
                        w_rem_nxt = r_rem - DUR_ONE;
                    end else if ((r_state == S_PLAY) && (GAP_TICKS > 0)) begin
                        w_rem_nxt   = GAP_LEN;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_addr_nxt  = w_adv_addr;
                        w_state_nxt = w_adv_state;
                    end
                end
                S_END: begin
                    // Address 0 here means entry 0 was the end marker: never loop an empty score.
                    if (loop && (r_addr != {ADDR_W{1'b0}})) begin
                        w_addr_nxt  = {ADDR_W{1'b0}};
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        w_select_nxt = (!stop && (r_state == S_PLAY)) ? r_note : REST;
        w_cnt_nxt    = (w_timed && (w_state_nxt == r_state) && !w_tick) ?
                       r_cnt + CNT_W'(1) : {CNT_W{1'b0}};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= {ADDR_W{1'b0}};
            r_note    <= REST;
            r_rem     <= {DUR_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_select  <= REST;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_addr    <= w_addr_nxt;
            r_note    <= w_note_nxt;
            r_rem     <= w_rem_nxt;
            r_cnt     <= w_cnt_nxt;
            r_select  <= w_select_nxt;
            r_playing <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign score_addr = r_addr;
    assign select     = r_select;
    assign playing    = r_playing;
    assign done       = r_done;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a score-timeline model predicts every output cycle,
// plus literal spot checks on the hand-computed cycle numbers.
module tb_note_sequencer;
    localparam int DIV  = 4;
    localparam int GAP  = 1;
    localparam int REST = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start, stop, loop;
    logic [1:0] score_addr;
    logic [7:0] score_data;
    logic [1:0] select;
    logic       playing, done;
    logic [7:0] rom [4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] addr;
        logic       playing;
        logic       done;
        logic       last;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;
    bit   pending = 1'b0;
    logic [1:0] end_addr = 2'd0;

    note_sequencer #(
        .CLK_HZ(8), .TICK_HZ(2), .SEL_W(2), .REST_SEL(3),
        .ADDR_W(2), .DUR_W(6), .GAP_TICKS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .score_addr(score_addr), .score_data(score_data),
        .select(select), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous score ROM.
    always @(posedge clk) score_data <= rom[score_addr];

    function automatic rec_t mk(input int s, input int a, input bit p, input bit d, input bit l);
        rec_t r;
        r.sel = 2'(s); r.addr = 2'(a); r.playing = p; r.done = d; r.last = l;
        return r;
    endfunction

    // Expand the score from address a0 into per-cycle expected outputs, up to the end point.
    task automatic push_from(input int a0);
        int a, d, s, len;
        bit fin;
        a = a0; fin = 1'b0;
        while (!fin) begin
            s = int'(rom[a][7:6]);
            d = int'(rom[a][5:0]);
            if (d == 0) begin
                exp_q.push_back(mk(REST, a, 1'b1, 1'b0, 1'b0));
                exp_q.push_back(mk(REST, a, 1'b1, 1'b0, 1'b0));
                exp_q.push_back(mk(REST, a, 1'b1, 1'b0, 1'b1));
                fin = 1'b1;
            end else begin
                len = 2 + (d + GAP) * DIV;
                for (int o = 0; o < len; o++)
                    exp_q.push_back(mk((o >= 3 && o <= 2 + d * DIV) ? s : REST, a, 1'b1, 1'b0, 1'b0));
                if (a == 3) begin
                    exp_q.push_back(mk(REST, 3, 1'b1, 1'b0, 1'b1));
                    fin = 1'b1;
                end else begin
                    a = a + 1;
                end
            end
        end
    endtask

    // Model: advance the expected timeline on each edge from the sampled controls.
    always @(posedge clk) begin
        bit took;
        cyc = cyc + 1;
        took = 1'b0;
        if (!rst_n) begin
            cur = mk(REST, 0, 1'b0, 1'b0, 1'b0);
        end else if (stop) begin
            exp_q.delete();
            pending = 1'b0;
            cur = mk(REST, int'(cur.addr), 1'b0, 1'b0, 1'b0);
        end else begin
            if (pending) begin
                pending = 1'b0;
                if (loop && end_addr != 2'd0) begin
                    push_from(0);
                end else begin
                    cur = mk(REST, int'(end_addr), 1'b0, 1'b1, 1'b0);
                    took = 1'b1;
                end
            end else if (exp_q.size() == 0 && start) begin
                push_from(0);
            end
            if (!took) begin
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    if (cur.last) begin
                        pending = 1'b1;
                        end_addr = cur.addr;
                    end
                end else begin
                    cur = mk(REST, int'(cur.addr), 1'b0, 1'b0, 1'b0);
                end
            end
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        pending = 1'b0;
        cur = mk(REST, 0, 1'b0, 1'b0, 1'b0);
    end

    // Compare DUT against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (select !== cur.sel || score_addr !== cur.addr ||
                playing !== cur.playing || done !== cur.done) begin
                n_fail++;
                $display("FAIL cycle %0d model: sel=%0d want %0d, addr=%0d want %0d, playing=%0b want %0b, done=%0b want %0b",
                         cyc, select, cur.sel, score_addr, cur.addr, playing, cur.playing, done, cur.done);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic at_cycle(input int k);
        while (cyc < t0 + k) @(negedge clk);
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        for (int i = 0; i < 4; i++) rom[i] = 8'h00;
        cur = mk(REST, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_select", int'(select), 3);
        check("rst_addr", int'(score_addr), 0);
        check("rst_playing", int'(playing), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single note {0,2} then end marker.
        rom[0] = 8'h02; rom[1] = 8'h40; rom[2] = 8'h00; rom[3] = 8'h00;
        pulse_start();
        check("one_addr0", int'(score_addr), 0);
        at_cycle(2);  check("one_pre", int'(select), 3);
        at_cycle(3);  check("one_first", int'(select), 0);
        at_cycle(10); check("one_lastnote", int'(select), 0);
        at_cycle(11); check("one_gap", int'(select), 3);
        at_cycle(16); check("one_nodone", int'(done), 0);
        at_cycle(17); check("one_done", int'(done), 1);
                      check("one_playing", int'(playing), 0);
        at_cycle(18); check("one_done_clr", int'(done), 0);
        at_cycle(20);

        // Four-note sequence, no loop, with ignored extra starts.
        rom[0] = 8'h41; rom[1] = 8'h81; rom[2] = 8'h01; rom[3] = 8'h41;
        pulse_start();
        at_cycle(3);  check("seq_n0", int'(select), 1);
        at_cycle(5);  start = 1'b1;
        at_cycle(6);  start = 1'b0;
        at_cycle(13); check("seq_n1", int'(select), 2);
        at_cycle(20); start = 1'b1;
        at_cycle(21); start = 1'b0;
        at_cycle(23); check("seq_n2", int'(select), 0);
        at_cycle(33); check("seq_n3", int'(select), 1);
        at_cycle(40); check("seq_end_nodone", int'(done), 0);
        at_cycle(41); check("seq_done", int'(done), 1);
                      check("seq_addr", int'(score_addr), 3);
        at_cycle(45); check("seq_idle", int'(playing), 0);

        // Looping, then drop loop mid-pass.
        loop = 1'b1;
        pulse_start();
        at_cycle(41); check("loop_addr0", int'(score_addr), 0);
                      check("loop_nodone", int'(done), 0);
        at_cycle(44); check("loop_replay", int'(select), 1);
        at_cycle(60); loop = 1'b0;
        at_cycle(81); check("loop_pre_done", int'(done), 0);
        at_cycle(82); check("loop_done", int'(done), 1);
        at_cycle(85);

        // Stop mid-note in the second entry, restart, stop, then start+stop while idle.
        rom[0] = 8'h81; rom[1] = 8'h45; rom[2] = 8'h01; rom[3] = 8'h41;
        pulse_start();
        at_cycle(15); check("stop_note", int'(select), 1);
                      stop = 1'b1;
        at_cycle(16); stop = 1'b0;
                      check("stop_select", int'(select), 3);
                      check("stop_playing", int'(playing), 0);
                      check("stop_done", int'(done), 0);
                      check("stop_addr", int'(score_addr), 1);
        at_cycle(20); check("stop_stays", int'(done), 0);
        pulse_start();
        check("restart_addr", int'(score_addr), 0);
        at_cycle(3);  check("restart_note", int'(select), 2);
        at_cycle(5);  stop = 1'b1;
        at_cycle(6);  stop = 1'b0;
        at_cycle(8);  start = 1'b1; stop = 1'b1;
        at_cycle(9);  start = 1'b0; stop = 1'b0;
                      check("startstop_idle", int'(playing), 0);
        at_cycle(12); check("startstop_still", int'(playing), 0);

        // Asynchronous reset mid-note.
        rom[0] = 8'h41; rom[1] = 8'h81; rom[2] = 8'h01; rom[3] = 8'h41;
        pulse_start();
        at_cycle(14); check("rstmid_note", int'(select), 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_select", int'(select), 3);
        check("rstmid_playing", int'(playing), 0);
        check("rstmid_addr", int'(score_addr), 0);
        check("rstmid_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Empty score with loop set.
        rom[0] = 8'h40; loop = 1'b1;
        pulse_start();
        at_cycle(2);  check("empty_nodone", int'(done), 0);
                      check("empty_playing", int'(playing), 1);
        at_cycle(3);  check("empty_done", int'(done), 1);
                      check("empty_idle", int'(playing), 0);
        at_cycle(6);  check("empty_stays", int'(playing), 0);
                      check("empty_done_clr", int'(done), 0);
        loop = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
